// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the multicycle datapath memory initiator.
// Contents: transaction FSM state enum, read-target constants and the
// region upper-bound helper used by the address classifier.
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ACCESS = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Read targets carried on req_kind_i
  localparam logic KIND_IR  = 1'b0;
  localparam logic KIND_MDR = 1'b1;

  localparam int unsigned WORD_BYTES = 4;

  // Exclusive byte upper bound of a region; computed wide so it never wraps
  function automatic logic [63:0] region_limit(input logic [63:0] base,
                                               input int unsigned depth);
    return base + 64'(depth) * 64'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/mem_region_check.sv
// Combinational address classifier for the unified ROM/RAM memory map.
// Ports:
//   addr    - byte address to classify
//   in_rom  - address lies in [ROM_BASE, ROM_BASE + 4*MEMORY_DEPTH)
//   in_ram  - address lies in [RAM_BASE, RAM_BASE + 4*MEMORY_DEPTH)
//   fault   - misaligned word address or address outside both regions
// Write policy (e.g. stores into ROM) is left to the caller.
module mem_region_check
  import mem_access_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0]  ROM_BASE     = DATA_WIDTH'(32'h0040_0000),
  parameter logic [DATA_WIDTH-1:0]  RAM_BASE     = DATA_WIDTH'(32'h1001_0000)
) (
  input  logic [DATA_WIDTH-1:0] addr,
  output logic                  in_rom,
  output logic                  in_ram,
  output logic                  fault
);

  localparam int unsigned EXT_W = DATA_WIDTH + 1;

  localparam logic [EXT_W-1:0] ROM_LO = EXT_W'(ROM_BASE);
  localparam logic [EXT_W-1:0] ROM_HI = EXT_W'(region_limit(64'(ROM_BASE), MEMORY_DEPTH));
  localparam logic [EXT_W-1:0] RAM_LO = EXT_W'(RAM_BASE);
  localparam logic [EXT_W-1:0] RAM_HI = EXT_W'(region_limit(64'(RAM_BASE), MEMORY_DEPTH));

  logic [EXT_W-1:0] addr_ext;

  // Unsigned range compare with one guard bit
  always_comb begin
    addr_ext = EXT_W'(addr);
    in_rom   = (addr_ext >= ROM_LO) && (addr_ext < ROM_HI);
    in_ram   = (addr_ext >= RAM_LO) && (addr_ext < RAM_HI);
    fault    = (addr[1:0] != 2'b00) || !(in_rom || in_ram);
  end

endmodule

// File: rtl/mem_access_master.sv
// Initiator side of the multicycle MIPS data-memory interface.
// Takes one fetch/load/store at a time from the control unit, classifies the
// address, drives the memory system, captures read data into IR or MDR and
// returns a one-cycle response with a fault flag.
// Ports:
//   clk_i, rst_n_i                  clock, async active-low reset
//   req_valid_i/req_ready_o         request handshake (ready only in IDLE)
//   req_we_i, req_kind_i            store select, read target (0 IR, 1 MDR)
//   req_addr_i, req_wdata_i         byte address, store data
//   Address_o, Write_Data_o,
//   write_enable_o, Read_Data_i     memory system interface
//   IR_o, MDR_o                     instruction / memory data registers
//   resp_valid_o, fault_o           completion pulse and fault flag
// Optional build macro MEM_ACCESS_COUNT_EN adds saturating 16-bit
// rd_count_o, wr_count_o and fault_count_o outcome counters.
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] ROM_BASE     = DATA_WIDTH'(32'h0040_0000),
  parameter logic [DATA_WIDTH-1:0] RAM_BASE     = DATA_WIDTH'(32'h1001_0000),
  parameter int unsigned           READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic                  req_kind_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  output logic                  write_enable_o,
  input  logic [DATA_WIDTH-1:0] Read_Data_i,
  output logic [DATA_WIDTH-1:0] IR_o,
  output logic [DATA_WIDTH-1:0] MDR_o,
  output logic                  resp_valid_o,
  output logic                  fault_o
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]           rd_count_o,
  output logic [15:0]           wr_count_o,
  output logic [15:0]           fault_count_o
`endif
);

  localparam int unsigned       CNT_W          = 2;
  localparam logic [CNT_W-1:0]  WAIT_LOAD      = CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic              READ_IMMEDIATE = (READ_LATENCY == 0);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic                  we_q, kind_q;
  logic                  accept_c, capture_c, chk_fault_c;
  logic                  rc_in_rom, rc_in_ram, rc_fault;

  assign accept_c = (state_q == IDLE) && req_valid_i;

  mem_region_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .ROM_BASE    (ROM_BASE),
    .RAM_BASE    (RAM_BASE)
  ) u_region_check (
    .addr  (addr_q),
    .in_rom(rc_in_rom),
    .in_ram(rc_in_ram),
    .fault (rc_fault)
  );

  // Stores must land in RAM and never in ROM (covers overlapping maps too)
  assign chk_fault_c = rc_fault || (we_q && (rc_in_rom || !rc_in_ram));

  // Next-state, wait counter and capture strobe
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE:   if (req_valid_i) state_d = CHECK;
      CHECK:  state_d = chk_fault_c ? RESP : ACCESS;
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else if (READ_IMMEDIATE) begin
          capture_c = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture_c = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request latch and registered memory/response outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      kind_q         <= KIND_IR;
      req_ready_o    <= 1'b1;
      Address_o      <= '0;
      Write_Data_o   <= '0;
      write_enable_o <= 1'b0;
      IR_o           <= '0;
      MDR_o          <= '0;
      resp_valid_o   <= 1'b0;
      fault_o        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_ready_o    <= (state_d == IDLE);
      write_enable_o <= (state_d == ACCESS) && we_q;
      resp_valid_o   <= (state_d == RESP);
      // Only CHECK can reach RESP with a fault, so the flag is one RESP wide
      fault_o        <= (state_q == CHECK) && chk_fault_c;
      if (accept_c) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        we_q    <= req_we_i;
        kind_q  <= req_kind_i;
      end
      if (state_d == ACCESS) begin
        Address_o    <= addr_q;
        Write_Data_o <= wdata_q;
      end
      if (capture_c) begin
        if (kind_q == KIND_IR) IR_o  <= Read_Data_i;
        else                   MDR_o <= Read_Data_i;
      end
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  // Saturating outcome counters, bumped on the cycle the response is shown
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_count_o    <= '0;
      wr_count_o    <= '0;
      fault_count_o <= '0;
    end else if (state_q == RESP) begin
      if (fault_o) begin
        if (fault_count_o != 16'hFFFF) fault_count_o <= fault_count_o + 16'd1;
      end else if (we_q) begin
        if (wr_count_o != 16'hFFFF) wr_count_o <= wr_count_o + 16'd1;
      end else begin
        if (rd_count_o != 16'hFFFF) rd_count_o <= rd_count_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_master.sv
// Scoreboard bench for mem_access_master with a small ROM/RAM memory model
// returning read data one cycle after the address is driven.
module tb_mem_access_master;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic        req_kind_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [31:0] Address_o;
  logic [31:0] Write_Data_o;
  logic        write_enable_o;
  logic [31:0] Read_Data_i;
  logic [31:0] IR_o;
  logic [31:0] MDR_o;
  logic        resp_valid_o;
  logic        fault_o;
`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0] rd_count_o, wr_count_o, fault_count_o;
`endif

  mem_access_master dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_kind_i    (req_kind_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .Address_o     (Address_o),
    .Write_Data_o  (Write_Data_o),
    .write_enable_o(write_enable_o),
    .Read_Data_i   (Read_Data_i),
    .IR_o          (IR_o),
    .MDR_o         (MDR_o),
    .resp_valid_o  (resp_valid_o),
    .fault_o       (fault_o)
`ifdef MEM_ACCESS_COUNT_EN
    ,
    .rd_count_o    (rd_count_o),
    .wr_count_o    (wr_count_o),
    .fault_count_o (fault_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: ROM words 0..63, RAM words 64..127, one-cycle read latency
  logic [31:0] mem [0:127];
  logic [31:0] rd_q = 32'h0;
  assign Read_Data_i = rd_q;

  function automatic logic [6:0] midx(input logic [31:0] a);
    return {a[28], a[7:2]};
  endfunction

  always @(posedge clk_i) begin
    if (write_enable_o) mem[midx(Address_o)] = Write_Data_o;
    rd_q <= mem[midx(Address_o)];
  end

  // Write strobe observer
  int          we_cnt  = 0;
  logic [31:0] we_addr = 32'h0;
  logic [31:0] we_data = 32'h0;
  always @(negedge clk_i) begin
    if (write_enable_o) begin
      we_cnt++;
      we_addr = Address_o;
      we_data = Write_Data_o;
    end
  end

  typedef struct {
    logic        fault;
    logic [31:0] ir;
    logic [31:0] mdr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   last_resp_cyc = -100;
  logic [31:0] model_ir  = 32'h0;
  logic [31:0] model_mdr = 32'h0;

  // Response monitor
  always @(negedge clk_i) begin
    if (rst_n_i && resp_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid_o), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_fault", 32'(fault_o), 32'(e.fault));
        chk("resp_ir",    IR_o,         e.ir);
        chk("resp_mdr",   MDR_o,        e.mdr);
        chk("resp_cycle", 32'(cyc),     32'(e.cyc));
      end
      last_resp_cyc = cyc;
    end
  end

  task automatic issue(input logic we, input logic kind, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_fault,
                       input logic [31:0] exp_rdata, input int lat,
                       input bit push, input bit b2b);
    int   t = 0;
    exp_t e;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_kind_i  = kind;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    while (!req_ready_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (!req_ready_o) begin
      chk("ready_timeout", 32'(req_ready_o), 32'h1);
      req_valid_i = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept", 32'(cyc), 32'(last_resp_cyc + 1));
    if (push) begin
      if (!exp_fault && !we) begin
        if (kind) model_mdr = exp_rdata;
        else      model_ir  = exp_rdata;
      end
      e.fault = exp_fault;
      e.ir    = model_ir;
      e.mdr   = model_mdr;
      e.cyc   = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
    @(negedge clk_i);
    chk("idle_fault_low", 32'(fault_o), 32'h0);
  endtask

  int we_before;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[2]   = 32'h2008_0005;   // 0x0040_0008
    mem[63]  = 32'hCAFE_0001;   // 0x0040_00FC, last ROM word
    mem[127] = 32'h1234_5678;   // 0x1001_00FC, last RAM word

    rst_n_i     = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_kind_i  = 1'b0;
    req_addr_i  = 32'h0;
    req_wdata_i = 32'h0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready",   32'(req_ready_o),    32'h1);
    chk("rst_we",      32'(write_enable_o), 32'h0);
    chk("rst_resp",    32'(resp_valid_o),   32'h0);
    chk("rst_ir",      IR_o,                32'h0);
    chk("rst_mdr",     MDR_o,               32'h0);
    chk("rst_addr",    Address_o,           32'h0);
    rst_n_i = 1'b1;

    // Fetch into IR: latency 4
    issue(1'b0, 1'b0, 32'h0040_0008, 32'h0, 1'b0, 32'h2008_0005, 4, 1'b1, 1'b0);
    drain();

    // Store to RAM: one write strobe with address and data, latency 3
    we_before = we_cnt;
    issue(1'b1, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, 32'h0, 3, 1'b1, 1'b0);
    drain();
    chk("store_we_pulses", 32'(we_cnt - we_before), 32'h1);
    chk("store_addr",      we_addr,                 32'h1001_0004);
    chk("store_data",      we_data,                 32'hDEAD_BEEF);

    // Store into ROM faults without a write strobe, latency 2
    we_before = we_cnt;
    issue(1'b1, 1'b0, 32'h0040_0000, 32'h5555_AAAA, 1'b1, 32'h0, 2, 1'b1, 1'b0);
    drain();
    chk("rom_store_no_we", 32'(we_cnt - we_before), 32'h0);

    // Misaligned then unmapped reads, back to back
    issue(1'b0, 1'b1, 32'h1001_0002, 32'h0, 1'b1, 32'h0, 2, 1'b1, 1'b0);
    issue(1'b0, 1'b0, 32'h2000_0000, 32'h0, 1'b1, 32'h0, 2, 1'b1, 1'b1);
    // RAM upper boundary, stored word readback, ROM boundaries
    issue(1'b0, 1'b1, 32'h1001_00FC, 32'h0, 1'b0, 32'h1234_5678, 4, 1'b1, 1'b1);
    issue(1'b0, 1'b1, 32'h1001_0100, 32'h0, 1'b1, 32'h0, 2, 1'b1, 1'b1);
    issue(1'b0, 1'b1, 32'h1001_0004, 32'h0, 1'b0, 32'hDEAD_BEEF, 4, 1'b1, 1'b1);
    issue(1'b0, 1'b0, 32'h0040_00FC, 32'h0, 1'b0, 32'hCAFE_0001, 4, 1'b1, 1'b1);
    issue(1'b0, 1'b0, 32'h003F_FFFC, 32'h0, 1'b1, 32'h0, 2, 1'b1, 1'b1);
    drain();

    // Reset during WAIT: outputs clear at once, no response follows
    issue(1'b0, 1'b0, 32'h1001_0004, 32'h0, 1'b0, 32'h0, 4, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    #1 rst_n_i = 1'b0;
    #1;
    chk("async_rst_addr",  Address_o,           32'h0);
    chk("async_rst_ir",    IR_o,                32'h0);
    chk("async_rst_mdr",   MDR_o,               32'h0);
    chk("async_rst_ready", 32'(req_ready_o),    32'h1);
    chk("async_rst_we",    32'(write_enable_o), 32'h0);
    model_ir  = 32'h0;
    model_mdr = 32'h0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("no_resp_after_rst", 32'(resp_valid_o), 32'h0);

`ifdef MEM_ACCESS_COUNT_EN
    chk("cnt_rd_rst",    32'(rd_count_o),    32'h0);
    chk("cnt_wr_rst",    32'(wr_count_o),    32'h0);
    chk("cnt_fault_rst", 32'(fault_count_o), 32'h0);
    issue(1'b0, 1'b0, 32'h0040_0008, 32'h0, 1'b0, 32'h2008_0005, 4, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 32'h1001_0008, 32'h0BAD_F00D, 1'b0, 32'h0, 3, 1'b1, 1'b1);
    issue(1'b0, 1'b1, 32'h1001_0002, 32'h0, 1'b1, 32'h0, 2, 1'b1, 1'b1);
    issue(1'b0, 1'b0, 32'h2000_0000, 32'h0, 1'b1, 32'h0, 2, 1'b1, 1'b1);
    drain();
    chk("cnt_rd",    32'(rd_count_o),    32'h1);
    chk("cnt_wr",    32'(wr_count_o),    32'h1);
    chk("cnt_fault", 32'(fault_count_o), 32'h2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
